// File: rtl/aa_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aa_fill_ctrl
// Purpose : 16 x 8 register array with bulk fill engine and 2-way RR write arbiter
// Rev     : 1.0  initial release
// ============================================================================
module aa_fill_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fill_start,
  input  logic [WIDTH-1:0]         fill_data,
  input  logic [1:0]               req,
  input  logic [$clog2(DEPTH)-1:0] wr_addr0,
  input  logic [$clog2(DEPTH)-1:0] wr_addr1,
  input  logic [WIDTH-1:0]         wr_data0,
  input  logic [WIDTH-1:0]         wr_data1,
  output logic [1:0]               gnt,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     busy,
  output logic                     done
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw-1:0] c_last = c_aw'(DEPTH - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_fill = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]       r_state;
  logic [c_aw-1:0]  r_cnt;
  logic [WIDTH-1:0] r_fill_val;
  logic             r_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  logic [1:0]       w_gnt;
  logic             w_we;
  logic [c_aw-1:0]  w_waddr;
  logic [WIDTH-1:0] w_wdata;

  // r_ptr = 1 means requester 1 wins the next contested cycle
  always_comb begin
    w_gnt = 2'b00;
    if (!rst && r_state == c_idle && !fill_start) begin
      case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == c_fill) begin
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = r_fill_val;
    end else if (w_gnt[0]) begin
      w_we    = 1'b1;
      w_waddr = wr_addr0;
      w_wdata = wr_data0;
    end else if (w_gnt[1]) begin
      w_we    = 1'b1;
      w_waddr = wr_addr1;
      w_wdata = wr_data1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_idle;
      r_cnt      <= '0;
      r_fill_val <= '0;
      r_ptr      <= 1'b0;
      r_rd_data  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Read samples before the write lands, so same-row access returns old data
      r_rd_data <= r_mem[rd_addr];
      if (w_we) begin
        r_mem[w_waddr] <= w_wdata;
      end
      case (r_state)
        c_idle: begin
          if (fill_start) begin
            r_fill_val <= fill_data;
            r_cnt      <= '0;
            r_state    <= c_fill;
          end else if (w_gnt != 2'b00) begin
            r_ptr <= w_gnt[0];
          end
        end
        c_fill: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= c_done;
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign gnt     = w_gnt;
  assign rd_data = r_rd_data;
  assign busy    = (r_state == c_fill);
  assign done    = (r_state == c_done);

endmodule
`default_nettype wire

// File: doc/aa_fill_ctrl.md
AA_FILL_CTRL -- requirements
Module: aa_fill_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, number of rows in the register array; fixed at 16 for this block.
REQ-002 Parameter WIDTH, default 8, bits per row.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fill_start  input  1  one-cycle request to write fill_data into every row.
REQ-006 fill_data  input  8  fill value, captured on the cycle fill_start is accepted.
REQ-007 req  input  2  write requests; bit n belongs to requester n.
REQ-008 wr_addr0, wr_addr1  input  4 each  row address for requester 0 and requester 1.
REQ-009 wr_data0, wr_data1  input  8 each  write data for requester 0 and requester 1.
REQ-010 gnt  output  2  combinational one-hot grant; the granted write commits on the same posedge.
REQ-011 rd_addr  input  4  read row address.
REQ-012 rd_data  output  8  registered read data.
REQ-013 busy  output  1  high while the FSM is in FILL.
REQ-014 done  output  1  one-cycle pulse when a fill completes.

Function
REQ-015 The block SHALL hold a 16 x 8 register array (rows 0..15) with one write port and one read port.
REQ-016 The FSM SHALL have the states IDLE, FILL and DONE.
REQ-017 IDLE: if fill_start=1, the block SHALL latch fill_data, clear the row counter to 0 and go to FILL; gnt SHALL be 00 in that cycle.
REQ-018 FILL: each cycle, row[counter] SHALL be written with the latched value and the counter SHALL increment; after the write to row 15 the FSM SHALL go to DONE (16 FILL cycles).
REQ-019 DONE: done SHALL be 1 for exactly this one cycle, gnt SHALL be 00, and the FSM SHALL return to IDLE.
REQ-020 fill_start SHALL be ignored in FILL and DONE, with no queuing.
REQ-021 gnt SHALL be 00 whenever the FSM is not in IDLE or fill_start=1.
REQ-022 IDLE arbitration: a single requester SHALL be granted; with req=11, the requester selected by the round-robin pointer SHALL be granted.
REQ-023 After each grant, the pointer SHALL move to the other requester; the pointer SHALL stay unchanged when no grant is given.
REQ-024 A granted write SHALL store wr_dataN into row wr_addrN at the posedge of the grant cycle; at most one write per cycle.
REQ-025 rd_data SHALL equal the row at rd_addr sampled at the previous posedge (1-cycle latency).
REQ-026 A read and a write to the same row in the same cycle SHALL return the old contents; the new value appears one cycle later.
REQ-027 busy SHALL be 1 exactly when the state is FILL.

Reset
REQ-028 While rst=1, independent of clk: state=IDLE, row counter=0, latched fill value=0, round-robin pointer favours requester 0, all rows=00, rd_data=00, done=0.
REQ-029 While rst=1, gnt SHALL be 00 and busy SHALL be 0.
REQ-030 Reset asserted during FILL SHALL abort the fill with no done pulse; the array SHALL read all-zero after release.

Verification
REQ-031 Reset, then rd_addr swept 0..15 -> rd_data=00 for every row; gnt=00, busy=0, done=0.
REQ-032 fill_start=1 with fill_data=A5 -> busy=1 for 16 cycles, done=1 for one cycle, then all 16 rows read A5.
REQ-033 req=11 held for 4 cycles after reset, wr_addr0=3/wr_data0=11, wr_addr1=7/wr_data1=22 -> gnt=01,10,01,10; row3=11, row7=22.
REQ-034 fill_start and req=01 in the same IDLE cycle -> gnt=00 and fill proceeds; req=01 held through FILL -> gnt=00 until the cycle after done, then gnt=01.
REQ-035 Write of 3C to row 5 with rd_addr=5 in the same cycle -> next-cycle rd_data=old value; following cycle rd_data=3C.
REQ-036 Fill of FF, rst pulsed after the 8th FILL cycle -> no done pulse; rows 0..15 read 00; a new fill of 5A completes normally.
